// File: rtl/pkt_framer_if.sv
// Framing channel between a packet requester and the strobe generator.
// master: the framer side; slave: the side issuing start/len/stall requests.
interface pkt_framer_if #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             stall;
    logic             ready;
    logic             head;
    logic             tail;
    logic             valid;
    logic [CNT_W-1:0] pkt_cnt;

    modport master (
        input  start, len, stall,
        output ready, head, tail, valid, pkt_cnt
    );

    modport slave (
        output start, len, stall,
        input  ready, head, tail, valid, pkt_cnt
    );
endinterface

// File: rtl/pkt_framer.sv
// Packet strobe generator: emits head, len-2 data words and a tail per request.
// Define PKT_FRAMER_BACK2BACK_EN to accept a new request on the tail edge (no bubble).
module pkt_framer #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic        clock,
    input  logic        reset,
    pkt_framer_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_DATA = 2'd2,
        S_TAIL = 2'd3
    } state_t;

    // State names the next word pending emission.
    state_t           r_state;
    state_t           w_state_next;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] w_rem_next;
    logic             r_head;
    logic             r_tail;
    logic             r_valid;
    logic [CNT_W-1:0] r_pkt_cnt;
    logic             w_head_next;
    logic             w_tail_next;
    logic             w_valid_next;
    logic [CNT_W-1:0] w_pkt_cnt_next;
    logic             w_ready;
    logic             w_accept;
    logic [LEN_W-1:0] w_len_rem;

`ifdef PKT_FRAMER_BACK2BACK_EN
    assign w_ready = (r_state == S_IDLE) | ((r_state == S_TAIL) & ~bus.stall);
`else
    assign w_ready = (r_state == S_IDLE);
`endif

    assign w_accept  = bus.start & w_ready;
    // Lengths 0 and 1 collapse to a head+tail packet.
    assign w_len_rem = (bus.len < LEN_W'(2)) ? '0 : bus.len - LEN_W'(2);

    always_comb begin
        w_state_next   = r_state;
        w_rem_next     = r_rem;
        w_head_next    = 1'b0;
        w_tail_next    = 1'b0;
        w_valid_next   = 1'b0;
        w_pkt_cnt_next = r_pkt_cnt;

        if (!bus.stall) begin
            case (r_state)
                S_HEAD: begin
                    w_head_next  = 1'b1;
                    w_valid_next = 1'b1;
                    w_state_next = (r_rem == '0) ? S_TAIL : S_DATA;
                end
                S_DATA: begin
                    w_valid_next = 1'b1;
                    w_rem_next   = r_rem - LEN_W'(1);
                    w_state_next = (r_rem == LEN_W'(1)) ? S_TAIL : S_DATA;
                end
                S_TAIL: begin
                    w_tail_next    = 1'b1;
                    w_valid_next   = 1'b1;
                    w_pkt_cnt_next = r_pkt_cnt + CNT_W'(1);
                    w_state_next   = S_IDLE;
                end
                default: ;
            endcase
        end

        if (w_accept) begin
            w_state_next = S_HEAD;
            w_rem_next   = w_len_rem;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_head    <= 1'b0;
            r_tail    <= 1'b0;
            r_valid   <= 1'b0;
            r_pkt_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_rem     <= w_rem_next;
            r_head    <= w_head_next;
            r_tail    <= w_tail_next;
            r_valid   <= w_valid_next;
            r_pkt_cnt <= w_pkt_cnt_next;
        end
    end

    assign bus.ready   = w_ready;
    assign bus.head    = r_head;
    assign bus.tail    = r_tail;
    assign bus.valid   = r_valid;
    assign bus.pkt_cnt = r_pkt_cnt;
endmodule

// File: tb/tb_pkt_framer.sv
// Directed bench for pkt_framer: expected {head,tail,valid} per cycle are hand-derived.
module tb_pkt_framer;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    pkt_framer_if #(.LEN_W(8), .CNT_W(8)) bus ();
    pkt_framer_if #(.LEN_W(8), .CNT_W(2)) bus2 ();

    pkt_framer #(.LEN_W(8), .CNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    pkt_framer #(.LEN_W(8), .CNT_W(2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if ({bus.head, bus.tail, bus.valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_htv got=%b exp=000", {bus.head, bus.tail, bus.valid});
        end
        checks++;
        if (bus.pkt_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d exp=0", bus.pkt_cnt);
        end
        checks++;
        if (bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", bus.ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_len5();
        logic [2:0] exp_v [7] = '{3'b000, 3'b101, 3'b001, 3'b001, 3'b001, 3'b011, 3'b000};
        bus.len = 8'd5;
        for (int i = 0; i < 7; i++) begin
            bus.start = (i == 0);
            step();
            bus.start = 1'b0;
            checks++;
            if ({bus.head, bus.tail, bus.valid} !== exp_v[i]) begin
                failures++;
                $display("FAIL len5_htv[%0d] got=%b exp=%b", i, {bus.head, bus.tail, bus.valid}, exp_v[i]);
            end
            if (i == 1) begin
                checks++;
                if (bus.ready !== 1'b0) begin
                    failures++;
                    $display("FAIL len5_busy_ready got=%b exp=0", bus.ready);
                end
            end
        end
        checks++;
        if (bus.pkt_cnt !== 8'd1) begin
            failures++;
            $display("FAIL len5_cnt got=%0d exp=1", bus.pkt_cnt);
        end
        $display("test_len5 done pkt_cnt=%0d", bus.pkt_cnt);
    endtask

    task automatic test_short(input logic [7:0] l, input logic [7:0] exp_cnt);
        logic [2:0] exp_v [4] = '{3'b000, 3'b101, 3'b011, 3'b000};
        bus.len = l;
        for (int i = 0; i < 4; i++) begin
            bus.start = (i == 0);
            step();
            bus.start = 1'b0;
            checks++;
            if ({bus.head, bus.tail, bus.valid} !== exp_v[i]) begin
                failures++;
                $display("FAIL short_len%0d_htv[%0d] got=%b exp=%b", l, i, {bus.head, bus.tail, bus.valid}, exp_v[i]);
            end
        end
        checks++;
        if (bus.pkt_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL short_len%0d_cnt got=%0d exp=%0d", l, bus.pkt_cnt, exp_cnt);
        end
        $display("test_short len=%0d done pkt_cnt=%0d", l, bus.pkt_cnt);
    endtask

    task automatic test_stall();
        logic [2:0] exp_v [10] = '{3'b000, 3'b101, 3'b001, 3'b001, 3'b000,
                                   3'b000, 3'b001, 3'b001, 3'b011, 3'b000};
        logic       stl_v [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bus.len = 8'd6;
        for (int i = 0; i < 10; i++) begin
            bus.start = (i == 0);
            bus.stall = stl_v[i];
            step();
            bus.start = 1'b0;
            bus.stall = 1'b0;
            checks++;
            if ({bus.head, bus.tail, bus.valid} !== exp_v[i]) begin
                failures++;
                $display("FAIL stall_htv[%0d] got=%b exp=%b", i, {bus.head, bus.tail, bus.valid}, exp_v[i]);
            end
        end
        checks++;
        if (bus.pkt_cnt !== 8'd4) begin
            failures++;
            $display("FAIL stall_cnt got=%0d exp=4", bus.pkt_cnt);
        end
        $display("test_stall done pkt_cnt=%0d", bus.pkt_cnt);
    endtask

    task automatic test_mid_reset();
        logic [2:0] exp_a [5] = '{3'b000, 3'b101, 3'b001, 3'b001, 3'b001};
        logic [2:0] exp_b [5] = '{3'b000, 3'b101, 3'b001, 3'b011, 3'b000};
        bus.len = 8'd10;
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 0);
            step();
            bus.start = 1'b0;
            checks++;
            if ({bus.head, bus.tail, bus.valid} !== exp_a[i]) begin
                failures++;
                $display("FAIL mrst_pre_htv[%0d] got=%b exp=%b", i, {bus.head, bus.tail, bus.valid}, exp_a[i]);
            end
        end
        reset = 1'b1;
        bus.start = 1'b1;
        step();
        reset = 1'b0;
        bus.start = 1'b0;
        checks++;
        if ({bus.head, bus.tail, bus.valid, bus.pkt_cnt} !== {3'b000, 8'd0}) begin
            failures++;
            $display("FAIL mrst_htv_cnt got=%b/%0d exp=000/0", {bus.head, bus.tail, bus.valid}, bus.pkt_cnt);
        end
        step();
        checks++;
        if ({bus.valid, bus.ready} !== 2'b01) begin
            failures++;
            $display("FAIL mrst_idle valid_ready got=%b exp=01", {bus.valid, bus.ready});
        end
        bus.len = 8'd3;
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 0);
            step();
            bus.start = 1'b0;
            checks++;
            if ({bus.head, bus.tail, bus.valid} !== exp_b[i]) begin
                failures++;
                $display("FAIL mrst_post_htv[%0d] got=%b exp=%b", i, {bus.head, bus.tail, bus.valid}, exp_b[i]);
            end
        end
        checks++;
        if (bus.pkt_cnt !== 8'd1) begin
            failures++;
            $display("FAIL mrst_cnt got=%0d exp=1", bus.pkt_cnt);
        end
        $display("test_mid_reset done pkt_cnt=%0d", bus.pkt_cnt);
    endtask

    task automatic test_back_to_back();
`ifdef PKT_FRAMER_BACK2BACK_EN
        logic [2:0] exp_v [9] = '{3'b000, 3'b101, 3'b001, 3'b011, 3'b101,
                                  3'b001, 3'b011, 3'b000, 3'b000};
`else
        logic [2:0] exp_v [9] = '{3'b000, 3'b101, 3'b001, 3'b011, 3'b000,
                                  3'b101, 3'b001, 3'b011, 3'b000};
`endif
        bus.len = 8'd3;
        for (int i = 0; i < 9; i++) begin
            bus.start = (i <= 4);
            step();
            checks++;
            if ({bus.head, bus.tail, bus.valid} !== exp_v[i]) begin
                failures++;
                $display("FAIL b2b_htv[%0d] got=%b exp=%b", i, {bus.head, bus.tail, bus.valid}, exp_v[i]);
            end
        end
        bus.start = 1'b0;
        checks++;
        if (bus.pkt_cnt !== 8'd3) begin
            failures++;
            $display("FAIL b2b_cnt got=%0d exp=3", bus.pkt_cnt);
        end
        $display("test_back_to_back done pkt_cnt=%0d", bus.pkt_cnt);
    endtask

    task automatic test_cnt_wrap();
        logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        bus2.len = 8'd2;
        for (int p = 0; p < 5; p++) begin
            bus2.start = 1'b1;
            step();
            bus2.start = 1'b0;
            step();
            step();
            checks++;
            if ({bus2.tail, bus2.pkt_cnt} !== {1'b1, exp_c[p]}) begin
                failures++;
                $display("FAIL wrap_cnt[%0d] tail_cnt got=%b/%0d exp=1/%0d", p, bus2.tail, bus2.pkt_cnt, exp_c[p]);
            end
            step();
            $display("test_cnt_wrap packet %0d pkt_cnt=%0d", p, bus2.pkt_cnt);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.len    = 8'd0;
        bus.stall  = 1'b0;
        bus2.start = 1'b0;
        bus2.len   = 8'd0;
        bus2.stall = 1'b0;
        test_reset();
        test_len5();
        test_short(8'd2, 8'd2);
        test_short(8'd0, 8'd3);
        test_stall();
        test_mid_reset();
        test_back_to_back();
        test_cnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
